// File: rtl/l2_flush_pkg.sv
// Shared types and default widths for the L2 flush/writeback arbiter.
// flush_entry_t is the default FIFO entry at default widths; the top builds its own at its parameters.
package l2_flush_pkg;

    localparam int DEFAULT_NUM_CORES = 2;
    localparam int DEFAULT_DATA_W    = 32;
    localparam int DEFAULT_TAG_W     = 24;
    localparam int DEFAULT_DEPTH     = 4;
    localparam int DEFAULT_ID_W      = $clog2(DEFAULT_NUM_CORES);
    localparam int DEFAULT_CNT_W     = $clog2(DEFAULT_DEPTH) + 1;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] data;
        logic [DEFAULT_TAG_W-1:0]  tag;
        logic [DEFAULT_ID_W-1:0]   core_id;
    } flush_entry_t;

endpackage

// File: rtl/l2_flush_fifo.sv
// Synchronous FIFO of flush entries with a fill-level counter.
// Storage is not reset; only pointers and count are, so head is meaningful only while count != 0.
module l2_flush_fifo
    import l2_flush_pkg::*;
#(
    parameter type entry_t = flush_entry_t,
    parameter int  DEPTH   = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_entry,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/l2_flush_arbiter.sv
// Round-robin arbiter collecting per-core flush requests into a FIFO drained by the L2.
// Grants are withheld while the FIFO is full, even if the L2 pops in the same cycle.
module l2_flush_arbiter
    import l2_flush_pkg::*;
#(
    parameter int NUM_CORES = DEFAULT_NUM_CORES,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int TAG_W     = DEFAULT_TAG_W,
    parameter int DEPTH     = DEFAULT_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CORES-1:0]           flush_valid,
    input  logic [NUM_CORES*DATA_W-1:0]    flush_data,
    input  logic [NUM_CORES*TAG_W-1:0]     flush_tag,
    output logic [NUM_CORES-1:0]           flush_ready,
    output logic [NUM_CORES-1:0]           stall_core,
    output logic                           l2_valid,
    input  logic                           l2_ready,
    output logic [DATA_W-1:0]              l2_data,
    output logic [TAG_W-1:0]               l2_tag,
    output logic [$clog2(NUM_CORES)-1:0]   l2_core_id,
    output logic [$clog2(DEPTH):0]         occupancy
);

    localparam int ID_W  = $clog2(NUM_CORES);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [ID_W-1:0]   core_id;
    } entry_t;

    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      winner;
    logic                 found;
    logic                 full;
    logic                 push;
    logic [NUM_CORES-1:0] grant;
    logic [CNT_W-1:0]     count;
    entry_t               push_entry;
    entry_t               head;

    assign full = (count == CNT_W'(DEPTH));

    // Search upward from rr_ptr with wrap; grant is also suppressed while reset is held.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        grant  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!found && flush_valid[(int'(rr_ptr) + k) % NUM_CORES]) begin
                found  = 1'b1;
                winner = ID_W'((int'(rr_ptr) + k) % NUM_CORES);
            end
        end
        if (found && !full && reset) grant[winner] = 1'b1;
    end

    assign push = |grant;

    always_comb begin
        push_entry         = '0;
        push_entry.data    = flush_data[winner*DATA_W +: DATA_W];
        push_entry.tag     = flush_tag[winner*TAG_W +: TAG_W];
        push_entry.core_id = winner;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (winner == ID_W'(NUM_CORES - 1)) ? '0 : winner + 1'b1;
        end
    end

    l2_flush_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (l2_valid && l2_ready),
        .head       (head),
        .count      (count)
    );

    assign flush_ready = grant;
    assign stall_core  = reset ? (flush_valid & ~grant) : '0;
    assign l2_valid    = (count != '0);
    assign l2_data     = l2_valid ? head.data : '0;
    assign l2_tag      = l2_valid ? head.tag : '0;
    assign l2_core_id  = l2_valid ? head.core_id : '0;
    assign occupancy   = count;

endmodule

// File: tb/tb_l2_flush_arbiter.sv
// Self-checking bench for l2_flush_arbiter (4 cores, depth 4) against a queue-based reference model.
module tb_l2_flush_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 24;
    localparam int DP = 4;
    localparam int IW = 2;
    localparam int OW = 3;

    logic            clk;
    logic            reset;
    logic [N-1:0]    flush_valid;
    logic [N*DW-1:0] flush_data;
    logic [N*TW-1:0] flush_tag;
    logic [N-1:0]    flush_ready;
    logic [N-1:0]    stall_core;
    logic            l2_valid;
    logic            l2_ready;
    logic [DW-1:0]   l2_data;
    logic [TW-1:0]   l2_tag;
    logic [IW-1:0]   l2_core_id;
    logic [OW-1:0]   occupancy;

    l2_flush_arbiter #(.NUM_CORES(N), .DATA_W(DW), .TAG_W(TW), .DEPTH(DP)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush_valid (flush_valid),
        .flush_data  (flush_data),
        .flush_tag   (flush_tag),
        .flush_ready (flush_ready),
        .stall_core  (stall_core),
        .l2_valid    (l2_valid),
        .l2_ready    (l2_ready),
        .l2_data     (l2_data),
        .l2_tag      (l2_tag),
        .l2_core_id  (l2_core_id),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        int            id;
    } ent_t;

    ent_t         q[$];
    int           rr;
    logic [N-1:0] last_g;
    int           compared;
    int           mismatched;

    // Reference arbitration: first requesting core at or after rr, only if the queue has room.
    function automatic logic [N-1:0] exp_grant();
        int c;
        if (q.size() >= DP) return '0;
        for (int k = 0; k < N; k++) begin
            c = (rr + k) % N;
            if (flush_valid[c]) return N'(1 << c);
        end
        return '0;
    endfunction

    task automatic new_data(input int c);
        flush_data[c*DW +: DW] = $urandom;
        flush_tag[c*TW +: TW]  = TW'($urandom);
    endtask

    // Advance the model and the DUT by one clock; returns at the following negedge.
    task automatic tick();
        logic [N-1:0] g;
        bit           pop;
        int           w;
        ent_t         e;
        g   = exp_grant();
        pop = (q.size() != 0) && l2_ready;
        w   = -1;
        for (int c = 0; c < N; c++) if (g[c]) w = c;
        e.d = '0; e.t = '0; e.id = 0;
        if (w >= 0) begin
            e.d  = flush_data[w*DW +: DW];
            e.t  = flush_tag[w*TW +: TW];
            e.id = w;
        end
        last_g = g;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (w >= 0) begin
            q.push_back(e);
            rr = (w + 1) % N;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        q.delete();
        rr = 0;
        last_g = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        l2_ready    = 1'b0;
        flush_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            new_data(0);
            tick();
        end
        #1;
        compared++;
        if (occupancy !== 3'd3) begin
            mismatched++; $display("FAIL reset_prefill_occ: got %0d expected 3", occupancy);
        end
        #1 reset = 1'b0;
        #1;
        q.delete(); rr = 0;
        compared++;
        if (occupancy !== 3'd0) begin
            mismatched++; $display("FAIL reset_occ: got %0d expected 0", occupancy);
        end
        compared++;
        if (l2_valid !== 1'b0 || l2_data !== '0 || l2_tag !== '0) begin
            mismatched++; $display("FAIL reset_l2: valid %0b data %0h tag %0h expected all 0", l2_valid, l2_data, l2_tag);
        end
        compared++;
        if (flush_ready !== '0 || stall_core !== '0) begin
            mismatched++; $display("FAIL reset_ready: ready %b stall %b expected 0000/0000", flush_ready, stall_core);
        end
        flush_valid = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_fairness();
        l2_ready    = 1'b1;
        new_data(0); new_data(1);
        flush_valid = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            #1;
            compared++;
            if (flush_ready !== ((i % 2 == 0) ? 4'b0001 : 4'b0010)) begin
                mismatched++; $display("FAIL fair_grant[%0d]: got %b expected %b", i, flush_ready, (i % 2 == 0) ? 4'b0001 : 4'b0010);
            end
            if (i > 0) begin
                compared++;
                if (l2_valid !== 1'b1 || l2_core_id !== IW'((i - 1) % 2)) begin
                    mismatched++; $display("FAIL fair_head_id[%0d]: valid %0b id %0d expected 1/%0d", i, l2_valid, l2_core_id, (i - 1) % 2);
                end
            end
            tick();
            for (int c = 0; c < N; c++) if (last_g[c]) new_data(c);
        end
        flush_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_full_stall();
        l2_ready    = 1'b0;
        flush_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            flush_data[0 +: DW] = 32'hAAAA_0000 + i;
            flush_tag[0 +: TW]  = 24'h000100 + i;
            #1;
            compared++;
            if (flush_ready !== ((i < 4) ? 4'b0001 : 4'b0000)) begin
                mismatched++; $display("FAIL stall_grant[%0d]: got %b expected %b", i, flush_ready, (i < 4) ? 4'b0001 : 4'b0000);
            end
            if (i < 4) tick();
        end
        compared++;
        if (occupancy !== 3'd4 || stall_core !== 4'b0001) begin
            mismatched++; $display("FAIL stall_full: occ %0d stall %b expected 4/0001", occupancy, stall_core);
        end
        flush_valid = '0;
        l2_ready    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            compared++;
            if (l2_valid !== 1'b1 || l2_data !== 32'hAAAA_0000 + i || l2_tag !== 24'h000100 + i) begin
                mismatched++; $display("FAIL drain_order[%0d]: valid %0b data %0h tag %0h expected 1/%0h/%0h", i, l2_valid, l2_data, l2_tag, 32'hAAAA_0000 + i, 24'h000100 + i);
            end
            tick();
        end
        #1;
        compared++;
        if (l2_valid !== 1'b0 || occupancy !== 3'd0) begin
            mismatched++; $display("FAIL drain_empty: valid %0b occ %0d expected 0/0", l2_valid, occupancy);
        end
    endtask

    task automatic test_full_no_bypass();
        l2_ready    = 1'b0;
        flush_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            new_data(0);
            tick();
        end
        flush_valid = 4'b0010;
        new_data(1);
        l2_ready = 1'b1;
        #1;
        compared++;
        if (flush_ready !== 4'b0000 || occupancy !== 3'd4) begin
            mismatched++; $display("FAIL nobypass_pop: ready %b occ %0d expected 0000/4", flush_ready, occupancy);
        end
        tick();
        l2_ready = 1'b0;
        #1;
        compared++;
        if (flush_ready !== 4'b0010 || occupancy !== 3'd3) begin
            mismatched++; $display("FAIL nobypass_next: ready %b occ %0d expected 0010/3", flush_ready, occupancy);
        end
        tick();
        flush_valid = '0;
        #1;
        compared++;
        if (occupancy !== 3'd4) begin
            mismatched++; $display("FAIL nobypass_refill: occ %0d expected 4", occupancy);
        end
        l2_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            compared++;
            if (l2_data !== q[0].d || l2_core_id !== IW'(q[0].id)) begin
                mismatched++; $display("FAIL nobypass_drain[%0d]: data %0h id %0d expected %0h/%0d", i, l2_data, l2_core_id, q[0].d, q[0].id);
            end
            tick();
        end
    endtask

    task automatic test_rr_skip();
        l2_ready    = 1'b1;
        flush_valid = 4'b0010;
        new_data(1);
        tick();
        flush_valid = '0;
        tick();
        new_data(1); new_data(3);
        flush_valid = 4'b1010;
        #1;
        compared++;
        if (flush_ready !== 4'b1000) begin
            mismatched++; $display("FAIL rr_first: got %b expected 1000", flush_ready);
        end
        tick();
        new_data(3);
        #1;
        compared++;
        if (flush_ready !== 4'b0010) begin
            mismatched++; $display("FAIL rr_second: got %b expected 0010", flush_ready);
        end
        tick();
        flush_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_drop();
        l2_ready    = 1'b0;
        flush_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            new_data(0);
            tick();
        end
        flush_valid = 4'b0100;
        new_data(2);
        #1;
        compared++;
        if (flush_ready !== 4'b0000 || stall_core !== 4'b0100) begin
            mismatched++; $display("FAIL drop_stall: ready %b stall %b expected 0000/0100", flush_ready, stall_core);
        end
        tick();
        flush_valid = '0;
        l2_ready    = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #1;
        compared++;
        if (l2_valid !== 1'b0 || occupancy !== 3'd0) begin
            mismatched++; $display("FAIL drop_no_push: valid %0b occ %0d expected 0/0", l2_valid, occupancy);
        end
        flush_valid = 4'b1111;
        for (int c = 0; c < N; c++) new_data(c);
        #1;
        compared++;
        if (flush_ready !== 4'b0010) begin
            mismatched++; $display("FAIL drop_ptr_hold: got %b expected 0010", flush_ready);
        end
        tick();
        flush_valid = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        ent_t         h;
        do_reset();
        flush_valid = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v = flush_valid;
            for (int c = 0; c < N; c++) begin
                if (v[c] && !last_g[c]) begin
                    if ($urandom_range(7) == 0) v[c] = 1'b0;
                end else begin
                    v[c] = ($urandom_range(1) == 1);
                    new_data(c);
                end
            end
            flush_valid = v;
            l2_ready    = ($urandom_range(2) != 0);
            #1;
            h.d = '0; h.t = '0; h.id = 0;
            if (q.size() != 0) h = q[0];
            compared++;
            if (flush_ready !== exp_grant() || stall_core !== (flush_valid & ~exp_grant())) begin
                mismatched++; $display("FAIL rand_grant[%0d]: ready %b stall %b expected %b/%b", cyc, flush_ready, stall_core, exp_grant(), flush_valid & ~exp_grant());
            end
            compared++;
            if (occupancy !== OW'(q.size()) || l2_valid !== (q.size() != 0)) begin
                mismatched++; $display("FAIL rand_occ[%0d]: occ %0d valid %0b expected %0d/%0b", cyc, occupancy, l2_valid, q.size(), q.size() != 0);
            end
            compared++;
            if (l2_data !== h.d || l2_tag !== h.t || l2_core_id !== IW'(h.id)) begin
                mismatched++; $display("FAIL rand_head[%0d]: data %0h tag %0h id %0d expected %0h/%0h/%0d", cyc, l2_data, l2_tag, l2_core_id, h.d, h.t, h.id);
            end
            tick();
        end
        flush_valid = '0;
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        reset       = 1'b0;
        flush_valid = '0;
        flush_data  = '0;
        flush_tag   = '0;
        l2_ready    = 1'b0;
        q.delete();
        rr     = 0;
        last_g = '0;
        @(negedge clk);
        do_reset();
        test_reset();
        test_fairness();
        test_full_stall();
        test_full_no_bypass();
        test_rr_skip();
        test_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
